laser_scan: RTL and testbench



---
 rtl/laser_scan.sv | 211 +++++++++++++++++++++
 tb/tb_laser_scan.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_scan.sv
// Two-circle laser placement engine: buffers a frame of target points, then alternately re-optimises two radius-R circles.
// Optional LASER_COVER_OUT_EN adds the COVER port carrying the union coverage count.
module laser_scan #(
    parameter int NPTS     = 40,
    parameter int CW       = 4,
    parameter int R        = 4,
    parameter int LANES    = 8,
    parameter int MAX_PASS = 6
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [CW-1:0] X,
    input  logic [CW-1:0] Y,
    input  logic          valid,
    output logic          ready,
    output logic [CW-1:0] C1X,
    output logic [CW-1:0] C1Y,
    output logic [CW-1:0] C2X,
    output logic [CW-1:0] C2Y,
    output logic          DONE
`ifdef LASER_COVER_OUT_EN
    ,
    output logic [$clog2(NPTS+1)-1:0] COVER
`endif
);

    localparam int NBLK = NPTS / LANES;
    localparam int CNTW = $clog2(NPTS + 1);
    localparam int IW   = (NPTS > 1) ? $clog2(NPTS) : 1;
    localparam int BW   = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int PW   = $clog2(MAX_PASS + 1);
    localparam int SQW  = 2 * CW + 2;
    localparam logic [SQW-1:0] R2 = SQW'(R * R);

    typedef enum logic [1:0] {READ, SCAN, PASS_END, FINISH} state_t;

    state_t state, next_state;

    logic [CW-1:0]   px [NPTS];
    logic [CW-1:0]   py [NPTS];
    logic [IW-1:0]   cnt;
    logic [CW-1:0]   cx, cy;
    logic [BW-1:0]   blk;
    logic [PW-1:0]   pass;
    logic [CNTW-1:0] acc, best_cnt, lane_cnt, total;
    logic [CW-1:0]   best_cx, best_cy, c1x, c1y, c2x, c2y;
    logic [NPTS-1:0] cand, cand_next, best_bm, bm1, bm2, excl;
    logic [IW-1:0]   idx;
    logic            hit, accept, last_blk, last_centre, same_centre, stop;

    // Signed differences are widened before squaring so no term can wrap.
    function automatic logic in_circle(input logic [CW-1:0] ax, input logic [CW-1:0] ay,
                                       input logic [CW-1:0] bx, input logic [CW-1:0] by);
        logic signed [CW:0]    dx, dy;
        logic signed [SQW-1:0] dxe, dye;
        logic [SQW-1:0]        d2;
        dx  = $signed({1'b0, ax}) - $signed({1'b0, bx});
        dy  = $signed({1'b0, ay}) - $signed({1'b0, by});
        dxe = {{(CW + 1){dx[CW]}}, dx};
        dye = {{(CW + 1){dy[CW]}}, dy};
        d2  = $unsigned(dxe * dxe) + $unsigned(dye * dye);
        return d2 <= R2;
    endfunction

`ifdef LASER_COVER_OUT_EN
    function automatic logic [CNTW-1:0] popcount(input logic [NPTS-1:0] v);
        logic [CNTW-1:0] n;
        n = '0;
        for (int i = 0; i < NPTS; i++) n = n + CNTW'(v[i]);
        return n;
    endfunction
`endif

    assign accept      = (state == READ) && valid && ready;
    assign last_blk    = (blk == BW'(NBLK - 1));
    assign last_centre = (cx == '1) && (cy == '1);
    assign total       = acc + lane_cnt;
    assign same_centre = pass[0] ? (best_cx == c2x && best_cy == c2y)
                                 : (best_cx == c1x && best_cy == c1y);
    assign stop        = ((pass >= PW'(2)) && same_centre) || (pass == PW'(MAX_PASS - 1));

    // Even passes place C1 against C2's bitmap, odd passes the reverse; pass 0 sees nothing.
    always_comb begin
        excl      = '0;
        cand_next = cand;
        lane_cnt  = '0;
        idx       = '0;
        hit       = 1'b0;
        if (pass != '0) excl = pass[0] ? bm1 : bm2;
        for (int i = 0; i < LANES; i++) begin
            idx            = IW'(int'(blk) * LANES + i);
            hit            = in_circle(px[idx], py[idx], cx, cy) && !excl[idx];
            cand_next[idx] = hit;
            lane_cnt       = lane_cnt + CNTW'(hit);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= READ;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            READ:     if (accept && cnt == IW'(NPTS - 1)) next_state = SCAN;
            SCAN:     if (last_blk && last_centre) next_state = PASS_END;
            PASS_END: next_state = stop ? FINISH : SCAN;
            FINISH:   next_state = READ;
            default:  next_state = READ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NPTS; i++) begin
                px[i] <= '0;
                py[i] <= '0;
            end
            ready    <= 1'b0;
            DONE     <= 1'b0;
            C1X      <= '0;
            C1Y      <= '0;
            C2X      <= '0;
            C2Y      <= '0;
`ifdef LASER_COVER_OUT_EN
            COVER    <= '0;
`endif
            cnt      <= '0;
            cx       <= '0;
            cy       <= '0;
            blk      <= '0;
            pass     <= '0;
            acc      <= '0;
            cand     <= '0;
            best_cnt <= '0;
            best_cx  <= '0;
            best_cy  <= '0;
            best_bm  <= '0;
            c1x      <= '0;
            c1y      <= '0;
            c2x      <= '0;
            c2y      <= '0;
            bm1      <= '0;
            bm2      <= '0;
        end else begin
            ready <= (next_state == READ);
            DONE  <= 1'b0;
            case (state)
                READ: begin
                    if (accept) begin
                        px[cnt] <= X;
                        py[cnt] <= Y;
                        cnt     <= cnt + 1'b1;
                    end
                end
                SCAN: begin
                    cand <= cand_next;
                    if (last_blk) begin
                        blk <= '0;
                        acc <= '0;
                        // Strict compare keeps the earliest centre in raster order on ties.
                        if (total > best_cnt) begin
                            best_cnt <= total;
                            best_cx  <= cx;
                            best_cy  <= cy;
                            best_bm  <= cand_next;
                        end
                        cx <= cx + 1'b1;
                        if (cx == '1) cy <= cy + 1'b1;
                    end else begin
                        blk <= blk + 1'b1;
                        acc <= total;
                    end
                end
                PASS_END: begin
                    if (pass[0]) begin
                        c2x <= best_cx;
                        c2y <= best_cy;
                        bm2 <= best_bm;
                    end else begin
                        c1x <= best_cx;
                        c1y <= best_cy;
                        bm1 <= best_bm;
                    end
                    best_cnt <= '0;
                    best_cx  <= '0;
                    best_cy  <= '0;
                    best_bm  <= '0;
                    pass     <= pass + 1'b1;
                end
                FINISH: begin
                    C1X  <= c1x;
                    C1Y  <= c1y;
                    C2X  <= c2x;
                    C2Y  <= c2y;
`ifdef LASER_COVER_OUT_EN
                    COVER <= popcount(bm1 | bm2);
`endif
                    DONE <= 1'b1;
                    cnt  <= '0;
                    pass <= '0;
                    bm1  <= '0;
                    bm2  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_laser_scan.sv
// Bench for laser_scan: a default-parameter instance and a small swept instance, checked against a
// brute-force placement model; COVER is checked when LASER_COVER_OUT_EN is defined.
module tb_laser_scan;

    logic       CLK = 1'b0;
    logic       RST;

    logic [3:0] xa, ya;
    logic       va, ready_a, done_a;
    logic [3:0] c1x_a, c1y_a, c2x_a, c2y_a;
    logic [2:0] xb, yb;
    logic       vb, ready_b, done_b;
    logic [2:0] c1x_b, c1y_b, c2x_b, c2y_b;
`ifdef LASER_COVER_OUT_EN
    logic [5:0] cover_a;
    logic [4:0] cover_b;
`endif

    laser_scan dut_a (
        .CLK(CLK), .RST(RST), .X(xa), .Y(ya), .valid(va), .ready(ready_a),
        .C1X(c1x_a), .C1Y(c1y_a), .C2X(c2x_a), .C2Y(c2y_a), .DONE(done_a)
`ifdef LASER_COVER_OUT_EN
        , .COVER(cover_a)
`endif
    );

    laser_scan #(.NPTS(16), .CW(3), .R(2), .LANES(16), .MAX_PASS(2)) dut_b (
        .CLK(CLK), .RST(RST), .X(xb), .Y(yb), .valid(vb), .ready(ready_b),
        .C1X(c1x_b), .C1Y(c1y_b), .C2X(c2x_b), .C2Y(c2y_b), .DONE(done_b)
`ifdef LASER_COVER_OUT_EN
        , .COVER(cover_b)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int fx [40];
    int fy [40];
    int e1x, e1y, e2x, e2y, ecov, epass;
    int h1x, h1y, h2x, h2y, hcov;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit covers(input int k, input int cx, input int cy, input int r);
        return (fx[k] - cx) * (fx[k] - cx) + (fy[k] - cy) * (fy[k] - cy) <= r * r;
    endfunction

    // Exhaustive placement: each pass scores every centre in raster order, first maximum wins.
    task automatic run_model(input bit sel);
        int  n, grid, r, maxp, best, bx, by, cnt;
        int  m1x, m1y, m2x, m2y;
        bit  m1 [40];
        bit  m2 [40];
        bit  mem [40];
        bit  fin;
        n = sel ? 16 : 40; grid = sel ? 8 : 16; r = sel ? 2 : 4; maxp = sel ? 2 : 6;
        m1x = 0; m1y = 0; m2x = 0; m2y = 0; epass = 0; fin = 0;
        for (int k = 0; k < 40; k++) begin m1[k] = 0; m2[k] = 0; end
        for (int p = 0; p < maxp && !fin; p++) begin
            best = 0; bx = 0; by = 0;
            for (int cy = 0; cy < grid; cy++)
                for (int cx = 0; cx < grid; cx++) begin
                    cnt = 0;
                    for (int k = 0; k < n; k++)
                        if (covers(k, cx, cy, r) && !((p % 2 == 0) ? m2[k] : m1[k])) cnt++;
                    if (cnt > best) begin best = cnt; bx = cx; by = cy; end
                end
            for (int k = 0; k < n; k++) mem[k] = covers(k, bx, by, r) && !((p % 2 == 0) ? m2[k] : m1[k]);
            epass = p + 1;
            if (p % 2 == 0) begin
                fin = (p >= 2) && bx == m1x && by == m1y;
                m1x = bx; m1y = by;
                for (int k = 0; k < n; k++) m1[k] = mem[k];
            end else begin
                fin = (p >= 2) && bx == m2x && by == m2y;
                m2x = bx; m2y = by;
                for (int k = 0; k < n; k++) m2[k] = mem[k];
            end
        end
        e1x = m1x; e1y = m1y; e2x = m2x; e2y = m2y; ecov = 0;
        for (int k = 0; k < n; k++) if (m1[k] || m2[k]) ecov++;
    endtask

    task automatic drive(input bit sel, input logic v, input int x, input int y);
        if (sel) begin vb = v; xb = 3'(x); yb = 3'(y); end
        else     begin va = v; xa = 4'(x); ya = 4'(y); end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? ready_b : ready_a;
    endfunction

    function automatic logic dn(input bit sel);
        return sel ? done_b : done_a;
    endfunction

    task automatic fill_two(input int n, input int x0, input int y0, input int x1, input int y1);
        for (int k = 0; k < n; k++) begin
            fx[k] = (k < n / 2) ? x0 : x1;
            fy[k] = (k < n / 2) ? y0 : y1;
        end
    endtask

    task automatic fill_random(input int n, input int maxc);
        int ax, ay, bx, by, j;
        ax = $urandom_range(0, maxc); ay = $urandom_range(0, maxc);
        bx = $urandom_range(0, maxc); by = $urandom_range(0, maxc);
        for (int k = 0; k < n; k++) begin
            j = $urandom_range(0, 4);
            fx[k] = (j == 0) ? $urandom_range(0, maxc) : (((j % 2) ? ax : bx) + $urandom_range(0, 2));
            fy[k] = (j == 0) ? $urandom_range(0, maxc) : (((j % 2) ? ay : by) + $urandom_range(0, 2));
            if (fx[k] > maxc) fx[k] = maxc;
            if (fy[k] > maxc) fy[k] = maxc;
        end
    endtask

    // Pushes the frame; returns at #1 after the edge that accepted the last point.
    task automatic apply_stimulus(input bit sel, input bit gaps);
        int  n, i, guard;
        bit  v;
        n = sel ? 16 : 40; i = 0; guard = 0;
        while (i < n && guard < 5000) begin
            @(negedge CLK);
            guard++;
            v = !(gaps && $urandom_range(0, 2) == 0);
            drive(sel, v, v ? fx[i] : int'($urandom_range(0, 7)), v ? fy[i] : 0);
            if (v && rdy(sel)) i++;
        end
        check_output("accepted", i, n);
        @(posedge CLK);
        #1;
        drive(sel, 1'b0, 0, 0);
        check_output("ready_drop", {31'b0, rdy(sel)}, 0);
    endtask

    // Counts edges after the accepting edge until DONE, optionally pulsing valid while ready is low.
    task automatic check_output_frame(input bit sel, input bit junk, input string tag);
        int lat, s;
        lat = -1;
        s = sel ? 65 : 1281;
        for (int c = 1; c <= 20000; c++) begin
            @(posedge CLK);
            #1;
            if (dn(sel) === 1'b1) begin lat = c; break; end
            if (junk && c < 60) drive(sel, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            else                drive(sel, 1'b0, 0, 0);
        end
        check_output({tag, "_latency"}, lat, epass * s + 1);
        check_output({tag, "_c1x"}, sel ? c1x_b : c1x_a, e1x);
        check_output({tag, "_c1y"}, sel ? c1y_b : c1y_a, e1y);
        check_output({tag, "_c2x"}, sel ? c2x_b : c2x_a, e2x);
        check_output({tag, "_c2y"}, sel ? c2y_b : c2y_a, e2y);
        check_output({tag, "_ready_at_done"}, {31'b0, rdy(sel)}, 1);
`ifdef LASER_COVER_OUT_EN
        check_output({tag, "_cover"}, sel ? cover_b : cover_a, ecov);
`endif
    endtask

    task automatic run_frame(input bit sel, input bit gaps, input bit junk, input string tag);
        run_model(sel);
        apply_stimulus(sel, gaps);
        check_output_frame(sel, junk, tag);
        @(posedge CLK);
        #1;
        check_output({tag, "_done_width"}, {31'b0, dn(sel)}, 0);
        check_output({tag, "_c1x_hold"}, sel ? c1x_b : c1x_a, e1x);
    endtask

    initial begin
        RST = 1'b1;
        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        #1;
        check_output("reset_ready", {31'b0, ready_a}, 0);
        check_output("reset_done", {31'b0, done_a}, 0);
        check_output("reset_c1", {c1x_a, c1y_a}, 0);
        check_output("reset_c2", {c2x_a, c2y_a}, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check_output("ready_after_reset_a", {31'b0, ready_a}, 1);
        check_output("ready_after_reset_b", {31'b0, ready_b}, 1);

        $display("[TB] single cluster");
        fill_two(40, 5, 5, 5, 5);
        run_frame(0, 0, 0, "single");

        $display("[TB] two clusters with gaps and stray valid");
        fill_two(40, 2, 2, 12, 12);
        run_frame(0, 1, 1, "two");

        $display("[TB] random frames");
        for (int t = 0; t < 2; t++) begin
            fill_random(40, 15);
            run_frame(0, 1, 1, "rand_a");
        end

        $display("[TB] reset during scan");
        fill_two(40, 3, 10, 3, 10);
        apply_stimulus(0, 0);
        repeat (500) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        check_output("midrst_ready", {31'b0, ready_a}, 0);
        check_output("midrst_done", {31'b0, done_a}, 0);
        check_output("midrst_c1", {c1x_a, c1y_a}, 0);
        check_output("midrst_c2", {c2x_a, c2y_a}, 0);
        @(posedge CLK);
        #2;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check_output("midrst_ready_release", {31'b0, ready_a}, 1);
        check_output("midrst_no_done", {31'b0, done_a}, 0);
        run_frame(0, 0, 0, "after_rst");

        $display("[TB] back-to-back frames");
        fill_two(40, 5, 5, 5, 5);
        run_model(0);
        apply_stimulus(0, 0);
        check_output_frame(0, 0, "b2b_a");
        h1x = e1x; h1y = e1y; h2x = e2x; h2y = e2y; hcov = ecov;
        fill_two(40, 2, 2, 12, 12);
        run_model(0);
        apply_stimulus(0, 0);
        check_output("b2b_hold_c1", {c1x_a, c1y_a}, {h1x[3:0], h1y[3:0]});
        check_output("b2b_hold_c2", {c2x_a, c2y_a}, {h2x[3:0], h2y[3:0]});
`ifdef LASER_COVER_OUT_EN
        check_output("b2b_hold_cover", cover_a, hcov);
`endif
        check_output_frame(0, 0, "b2b_b");

        $display("[TB] swept instance");
        fill_two(16, 7, 7, 7, 7);
        run_frame(1, 0, 0, "sweep");
        fill_random(16, 7);
        run_frame(1, 1, 1, "sweep_rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
